// File: rtl/music_ctrl_pkg.sv
// Shared types for the music sequencer: FSM state encoding and the song table.
package music_ctrl_pkg;

    // Controller states. The numeric values are visible on state_o.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // One song table entry: first ROM address and number of notes (>= 1).
    typedef struct packed {
        logic [7:0] start;
        logic [7:0] len;
    } song_t;

    localparam int NUM_SONGS = 4;

    // Song table. Every entry satisfies start + len - 1 <= 255, so the
    // 8-bit address arithmetic never wraps inside a song.
    function automatic song_t song_lookup(input logic [1:0] idx);
        song_t entry;
        case (idx)
            2'd0:    entry = '{start: 8'd0,  len: 8'd3};
            2'd1:    entry = '{start: 8'd16, len: 8'd4};
            2'd2:    entry = '{start: 8'd32, len: 8'd2};
            default: entry = '{start: 8'd48, len: 8'd5};
        endcase
        return entry;
    endfunction

    // Address of the last note of a song.
    function automatic logic [7:0] song_last(input song_t entry);
        return entry.start + entry.len - 8'd1;
    endfunction

    // Song selected out of reset.
    localparam song_t SONG0 = song_lookup(2'd0);

endpackage

// File: rtl/music_seq_ctrl_beat_timer.sv
// Beat timer: counts 0..BEAT_CYC-1 while enabled, pulses at the terminal
// count and flags the muted gap at the end of each beat.
module beat_timer #(
    parameter int BEAT_CYC = 12_500_000,
    parameter int GAP_CYC  = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o,
    output logic gap_o
);

    localparam int CW = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
    localparam logic [CW-1:0] TERM = CW'(BEAT_CYC - 1);

    logic [CW-1:0] count_q, count_d;
    logic          at_term;

    // Next count: clear wins over enable, wrap at the terminal count.
    always_comb begin
        at_term = (count_q == TERM);
        count_d = count_q;
        tick_o  = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (at_term) begin
                count_d = '0;
                tick_o  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Gap flag covers the last GAP_CYC counts of the beat.
    generate
        if (GAP_CYC > 0) begin : g_gap
            localparam logic [CW-1:0] GAP_START = CW'(BEAT_CYC - GAP_CYC);
            assign gap_o = (count_q >= GAP_START);
        end else begin : g_no_gap
            assign gap_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/music_seq_ctrl.sv
// Music sequencer controller: walks a song's notes in an external
// synchronous ROM, one note per beat, with pause, stop, loop and song select.
// A beat must span more than the two fetch cycles (BEAT_CYC > 2).
module music_seq_ctrl
    import music_ctrl_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BEAT_HZ = 4,
    parameter int GAP_CYC = 500_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       play_pause_i,
    input  logic       stop_i,
    input  logic [1:0] song_sel_i,
    input  logic       song_load_i,
    input  logic       loop_en_i,
    output logic [7:0] rom_addr_o,
    input  logic [3:0] rom_data_i,
    output logic [3:0] note_o,
    output logic       beat_o,
    output logic [2:0] state_o
);

    localparam int BEAT_CYC = CLK_HZ / BEAT_HZ;

    state_e     state_q, state_d;
    logic [1:0] song_q, song_d;
    logic [7:0] cur_addr_q, cur_addr_d;
    logic [3:0] note_q, note_d;
    logic       beat_q, beat_d;
    logic       fetch_wait_q, fetch_wait_d;   // second FETCH cycle: ROM data valid
    logic       pause_pend_q, pause_pend_d;   // play_pause seen in first FETCH cycle

    logic       idle_like;
    logic       load_ok;
    logic       start_evt;
    logic [1:0] song_eff;
    song_t      entry_eff;
    logic [7:0] start_eff;
    logic       is_last;
    logic       timer_en;
    logic       timer_clr;
    logic       timer_tick;
    logic       timer_gap;

    // Shared decode: song selection, song bounds and timer controls.
    always_comb begin
        idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
        load_ok   = song_load_i && idle_like;
        song_eff  = load_ok ? song_sel_i : song_q;
        entry_eff = song_lookup(song_eff);
        start_eff = entry_eff.start;
        is_last   = (cur_addr_q == song_last(entry_eff));
        start_evt = idle_like && play_pause_i && !stop_i;
        timer_clr = stop_i || start_evt;
        // The beat keeps running through the fetch so notes stay on the grid;
        // the pause request freezes it on the very edge it is seen.
        timer_en  = (state_q == ST_FETCH) ||
                    ((state_q == ST_PLAY) && !play_pause_i);
    end

    beat_timer #(
        .BEAT_CYC (BEAT_CYC),
        .GAP_CYC  (GAP_CYC)
    ) u_beat_timer (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .en_i   (timer_en),
        .clr_i  (timer_clr),
        .tick_o (timer_tick),
        .gap_o  (timer_gap)
    );

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; stop overrides everything else.
    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (play_pause_i) begin
                        state_d = ST_FETCH;
                    end else if (load_ok) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (fetch_wait_q) begin
                        state_d = (play_pause_i || pause_pend_q) ? ST_PAUSE : ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (play_pause_i) begin
                        state_d = ST_PAUSE;
                    end else if (timer_tick) begin
                        state_d = (is_last && !loop_en_i) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_PAUSE: begin
                    if (play_pause_i) begin
                        state_d = ST_PLAY;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: song select, note address, latched note, beat pulse.
    always_comb begin
        song_d       = song_eff;
        cur_addr_d   = cur_addr_q;
        note_d       = note_q;
        fetch_wait_d = 1'b0;
        pause_pend_d = 1'b0;
        beat_d       = timer_tick;
        if (stop_i) begin
            cur_addr_d = start_eff;
            note_d     = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (play_pause_i || load_ok) begin
                        cur_addr_d = start_eff;
                        note_d     = 4'd0;
                    end
                end
                ST_FETCH: begin
                    if (!fetch_wait_q) begin
                        fetch_wait_d = 1'b1;
                        pause_pend_d = play_pause_i;
                    end else begin
                        note_d = rom_data_i;
                    end
                end
                ST_PLAY: begin
                    if (timer_tick) begin
                        if (!is_last) begin
                            cur_addr_d = cur_addr_q + 8'd1;
                        end else if (loop_en_i) begin
                            cur_addr_d = start_eff;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            song_q       <= 2'd0;
            cur_addr_q   <= SONG0.start;
            note_q       <= 4'd0;
            beat_q       <= 1'b0;
            fetch_wait_q <= 1'b0;
            pause_pend_q <= 1'b0;
        end else begin
            song_q       <= song_d;
            cur_addr_q   <= cur_addr_d;
            note_q       <= note_d;
            beat_q       <= beat_d;
            fetch_wait_q <= fetch_wait_d;
            pause_pend_q <= pause_pend_d;
        end
    end

    // Outputs: the note sounds only while playing and outside the gap.
    always_comb begin
        rom_addr_o = cur_addr_q;
        state_o    = state_q;
        beat_o     = beat_q;
        note_o     = ((state_q == ST_PLAY) && !timer_gap) ? note_q : 4'd0;
    end

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Directed bench for music_seq_ctrl with a scoreboard of expected fetches.
module tb_music_seq_ctrl;
    import music_ctrl_pkg::*;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       play_pause_i;
    logic       stop_i;
    logic [1:0] song_sel_i;
    logic       song_load_i;
    logic       loop_en_i;
    logic [7:0] rom_addr_o;
    logic [3:0] rom_data_i;
    logic [3:0] note_o;
    logic       beat_o;
    logic [2:0] state_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] note;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [3:0] rom [256];
    logic [2:0] prev_state;

    music_seq_ctrl #(
        .CLK_HZ  (100),
        .BEAT_HZ (10),
        .GAP_CYC (2)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .play_pause_i (play_pause_i),
        .stop_i       (stop_i),
        .song_sel_i   (song_sel_i),
        .song_load_i  (song_load_i),
        .loop_en_i    (loop_en_i),
        .rom_addr_o   (rom_addr_o),
        .rom_data_i   (rom_data_i),
        .note_o       (note_o),
        .beat_o       (beat_o),
        .state_o      (state_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Synchronous ROM model.
    always @(posedge sys_clk) rom_data_i <= rom[rom_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [3:0] n);
        exp_t e;
        e.addr = a;
        e.note = n;
        sb_q.push_back(e);
    endtask

    task automatic pulse_pp();
        play_pause_i = 1'b1;
        @(negedge sys_clk);
        play_pause_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        @(negedge sys_clk);
        stop_i = 1'b0;
    endtask

    task automatic pulse_load(input logic [1:0] sel);
        song_sel_i  = sel;
        song_load_i = 1'b1;
        @(negedge sys_clk);
        song_load_i = 1'b0;
    endtask

    // Scoreboard: each completed fetch (FETCH -> PLAY) consumes one entry.
    always @(negedge sys_clk) begin
        if (sys_rst_n && prev_state == ST_FETCH && state_o == ST_PLAY) begin
            tests++;
            assert (sb_q.size() != 0) else begin
                fails++;
                $error("FAIL sb_underflow: observed note %0h at addr %0h, expected none", note_o, rom_addr_o);
            end
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("sb_addr", rom_addr_o, mon_e.addr);
                chk("sb_note", note_o, mon_e.note);
            end
        end
        prev_state = state_o;
    end

    initial begin
        int c;
        int b;
        for (int i = 0; i < 256; i++) rom[i] = 4'hF;
        rom[0]  = 4'd1;
        rom[1]  = 4'd2;
        rom[2]  = 4'd3;
        rom[32] = 4'd5;
        rom[33] = 4'd6;
        sys_rst_n    = 1'b0;
        play_pause_i = 1'b0;
        stop_i       = 1'b0;
        song_sel_i   = 2'd0;
        song_load_i  = 1'b0;
        loop_en_i    = 1'b0;
        prev_state   = 3'd0;

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_state", state_o, ST_IDLE);
        chk("rst_note", note_o, 0);
        chk("rst_beat", beat_o, 0);
        chk("rst_addr", rom_addr_o, 0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("idle_state", state_o, ST_IDLE);

        // Song 0 played once: notes 1,2,3 every 10 cycles, gap mute, DONE at 30
        push_exp(8'd0, 4'd1);
        push_exp(8'd1, 4'd2);
        push_exp(8'd2, 4'd3);
        pulse_pp();
        chk("start_state", state_o, ST_FETCH);
        chk("start_addr", rom_addr_o, 0);
        for (int t = 1; t <= 30; t++) begin
            @(negedge sys_clk);
            c = t % 10;
            b = t / 10;
            if (c >= 2 && c <= 7) chk("note_play", note_o, b + 1);
            else if (c >= 8) chk("note_gap", note_o, 0);
            chk("beat", beat_o, (c == 0) ? 1 : 0);
            if (t == 10) chk("addr_beat1", rom_addr_o, 1);
            if (t == 20) chk("addr_beat2", rom_addr_o, 2);
        end
        chk("done_state", state_o, ST_DONE);
        @(negedge sys_clk);
        chk("done_note", note_o, 0);

        // Loop enabled: wraps to address 0, never DONE; then stop + play together
        loop_en_i = 1'b1;
        push_exp(8'd0, 4'd1);
        push_exp(8'd1, 4'd2);
        push_exp(8'd2, 4'd3);
        push_exp(8'd0, 4'd1);
        push_exp(8'd1, 4'd2);
        pulse_pp();
        for (int t = 1; t <= 44; t++) begin
            @(negedge sys_clk);
            chk("loop_not_done", (state_o == ST_DONE) ? 1 : 0, 0);
            if (t == 30) chk("loop_addr_wrap", rom_addr_o, 0);
            if (t == 32) chk("loop_note_again", note_o, 1);
        end
        loop_en_i    = 1'b0;
        stop_i       = 1'b1;
        play_pause_i = 1'b1;
        @(negedge sys_clk);
        stop_i       = 1'b0;
        play_pause_i = 1'b0;
        chk("stop_pp_state", state_o, ST_IDLE);
        chk("stop_pp_note", note_o, 0);
        chk("stop_pp_addr", rom_addr_o, 0);

        // Pause at beat count 4, hold 20 cycles, resume: beat 6 cycles later
        push_exp(8'd0, 4'd1);
        pulse_pp();
        repeat (4) @(negedge sys_clk);
        pulse_pp();
        chk("pause_state", state_o, ST_PAUSE);
        chk("pause_note", note_o, 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge sys_clk);
            chk("pause_hold_state", state_o, ST_PAUSE);
            chk("pause_hold_beat", beat_o, 0);
        end
        pulse_pp();
        chk("resume_state", state_o, ST_PLAY);
        chk("resume_note", note_o, 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge sys_clk);
            chk("resume_beat", beat_o, (k == 6) ? 1 : 0);
        end
        chk("resume_addr", rom_addr_o, 1);
        pulse_stop();
        chk("stop_state", state_o, ST_IDLE);

        // Song load ignored during PLAY, accepted in DONE
        push_exp(8'd0, 4'd1);
        pulse_pp();
        repeat (4) @(negedge sys_clk);
        pulse_load(2'd2);
        chk("load_play_state", state_o, ST_PLAY);
        chk("load_play_addr", rom_addr_o, 0);
        push_exp(8'd1, 4'd2);
        push_exp(8'd2, 4'd3);
        repeat (25) @(negedge sys_clk);
        chk("load_done_state", state_o, ST_DONE);
        pulse_load(2'd2);
        chk("load_idle_state", state_o, ST_IDLE);
        push_exp(8'd32, 4'd5);
        push_exp(8'd33, 4'd6);
        pulse_pp();
        chk("song2_addr0", rom_addr_o, 32);
        repeat (10) @(negedge sys_clk);
        chk("song2_addr1", rom_addr_o, 33);
        repeat (10) @(negedge sys_clk);
        chk("song2_done", state_o, ST_DONE);

        // Reset mid-beat: immediate effect, no residual beat, replays song 0
        push_exp(8'd32, 4'd5);
        pulse_pp();
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("arst_state", state_o, ST_IDLE);
        chk("arst_note", note_o, 0);
        chk("arst_beat", beat_o, 0);
        chk("arst_addr", rom_addr_o, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge sys_clk);
            chk("post_rst_beat", beat_o, 0);
            chk("post_rst_state", state_o, ST_IDLE);
        end
        push_exp(8'd0, 4'd1);
        pulse_pp();
        chk("post_rst_addr", rom_addr_o, 0);
        repeat (2) @(negedge sys_clk);
        pulse_stop();

        // Load and play in the same IDLE cycle start the new song
        push_exp(8'd32, 4'd5);
        song_sel_i   = 2'd2;
        song_load_i  = 1'b1;
        play_pause_i = 1'b1;
        @(negedge sys_clk);
        song_load_i  = 1'b0;
        play_pause_i = 1'b0;
        chk("load_pp_state", state_o, ST_FETCH);
        chk("load_pp_addr", rom_addr_o, 32);
        repeat (2) @(negedge sys_clk);
        pulse_stop();
        chk("stop_song2_addr", rom_addr_o, 32);

        // Play/pause during FETCH is deferred into PAUSE with the note latched
        pulse_load(2'd0);
        chk("reload0_addr", rom_addr_o, 0);
        pulse_pp();
        pulse_pp();
        @(negedge sys_clk);
        chk("fetch_pause_state", state_o, ST_PAUSE);
        chk("fetch_pause_note", note_o, 0);
        pulse_pp();
        chk("fetch_resume_state", state_o, ST_PLAY);
        chk("fetch_resume_note", note_o, 1);

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
